uart_rx: RTL

//   Serial receiver for the core's rxd pin. Mirror of uart_tx: 8N1-style frame, LSB first.

---
 rtl/uart_pkg.sv | 13 +
 rtl/bit_sync.sv | 23 ++
 rtl/uart_rx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: ce-paced, LSB-first frame capture with a one-entry valid/ack holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SIZE         = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          i_rx,
    input  logic          i_data_ack,
    output logic [SIZE:0] o_data_byte,
    output logic          o_data_valid,
    output logic          o_active,
    output logic          o_frame_error,
    output logic          o_overrun
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IW   = cnt_width(SIZE + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    // The IDLE tick that saw the falling edge counts as the first start-bit tick.
    localparam logic [CW-1:0] START_LAST = CW'(HALF - 2);
    localparam logic [IW-1:0] IDX_LAST   = IW'(SIZE);

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] bit_idx;
    logic [SIZE:0] shift;
    logic          rx;
    logic          deliver;

    bit_sync #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (i_rx),
        .q      (rx)
    );

    assign deliver = ce && (state == STOP) && (cnt == BIT_LAST) && rx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            o_active      <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            o_frame_error <= 1'b0;
            if (ce) begin
                case (state)
                    IDLE: begin
                        if (!rx) begin
                            state    <= START;
                            cnt      <= '0;
                            o_active <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt == START_LAST) begin
                            cnt <= '0;
                            if (!rx) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state    <= IDLE;
                                o_active <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt            <= '0;
                            shift[bit_idx] <= rx;
                            if (bit_idx == IDX_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt == BIT_LAST) begin
                            cnt      <= '0;
                            o_active <= 1'b0;
                            if (rx) begin
                                state <= IDLE;
                            end else begin
                                state         <= WAIT_HIGH;
                                o_frame_error <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        o_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Ack is honoured every clk; a delivery in the same clk as an ack takes the slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_data_byte  <= '0;
            o_data_valid <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (deliver) begin
            if (!o_data_valid || i_data_ack) begin
                o_data_byte  <= shift;
                o_data_valid <= 1'b1;
            end else begin
                o_overrun <= 1'b1;
            end
        end else if (i_data_ack && o_data_valid) begin
            o_data_valid <= 1'b0;
            o_overrun    <= 1'b0;
        end
    end

endmodule
